id_ex_stage_register: RTL and testbench

//  ID/EX pipeline register of the RV32IM core. Captures decoded operands, control bundle and the

---
 rtl/core_pkg.sv | 25 ++
 rtl/id_ex_stage_register_if.sv | 32 +++
 rtl/id_ex_stage_register.sv | 164 ++++++++++++++++
 tb/tb_id_ex_stage_register.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants: control bundle bit map, forward selects, ID/EX hold states
// Purpose: constants shared by the ID/EX register, its interface and its testbench.
// Ports: none (package).
package core_pkg;

  // Decoded control bundle width and bit positions
  localparam int CTRL_W         = 12;
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_ALU_SRC   = 3;  // 1: operand B is the immediate, 0: ALU reg-reg

  // Hazard-unit forward selects
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MA   = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b11;

  // RUN: no multi-cycle op seen last edge; FROZEN: hold_ex was high last edge
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } hold_state_t;

endpackage

// File: rtl/id_ex_stage_register_if.sv
// rtl/id_ex_stage_register_if.sv - one pipeline-stage instruction bundle (ID side or EX side)
// Purpose: groups the per-instruction fields carried across the ID/EX boundary.
// Ports (fields): valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, ctrl,
//   fwd_a / fwd_b / fwd_st (forward selects for rs1 / rs2 / store data).
// Modports: master drives the bundle, slave receives it.
interface id_ex_stage_register_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = core_pkg::CTRL_W
) ();

  logic              valid;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [CTRL_W-1:0] ctrl;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [1:0]        fwd_st;

  modport master (
    output valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, ctrl, fwd_a, fwd_b, fwd_st
  );

  modport slave (
    input valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, ctrl, fwd_a, fwd_b, fwd_st
  );

endinterface

// File: rtl/id_ex_stage_register.sv
// rtl/id_ex_stage_register.sv - ID/EX pipeline register with bubble insertion and multi-cycle freeze
// Purpose: captures the decoded ID instruction for EX one cycle later, inserts bubbles on
//   flush/stall, and freezes while EX runs a multi-cycle M-op, snapshotting forwarded operands
//   on the first frozen edge so later stages can drain underneath.
// Ports:
//   CLK, RESETn        clock, asynchronous active-low reset
//   id_in (slave)      ID instruction bundle, incl. hazard forward selects
//   stall_pipeline     load-use stall, flush_ex taken branch kill, hold_ex EX busy
//   ex_op_a_res/ex_op_b_res/ex_store_res  post-forward operand values from EX
//   ex_out (master)    registered EX instruction bundle
//   ex_reg_write, ex_is_load  qualified control bits for the hazard unit
//   front_hold         freeze PC and IF/ID this cycle
//   bubble_cnt         saturating count of inserted bubbles
module id_ex_stage_register #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = core_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  id_ex_stage_register_if.slave   id_in,
  input  logic                    stall_pipeline,
  input  logic                    flush_ex,
  input  logic                    hold_ex,
  input  logic [XLEN-1:0]         ex_op_a_res,
  input  logic [XLEN-1:0]         ex_op_b_res,
  input  logic [XLEN-1:0]         ex_store_res,
  id_ex_stage_register_if.master  ex_out,
  output logic                    ex_reg_write,
  output logic                    ex_is_load,
  output logic                    front_hold,
  output logic [CNT_W-1:0]        bubble_cnt
);

  import core_pkg::*;

  logic              valid_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   rs2_data_q;
  logic [XLEN-1:0]   imm_q;
  logic [4:0]        rs1_q;
  logic [4:0]        rs2_q;
  logic [4:0]        rd_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [1:0]        fwd_a_q;
  logic [1:0]        fwd_b_q;
  logic [1:0]        fwd_st_q;
  logic [CNT_W-1:0]  cnt_q;

  hold_state_t state_q;
  hold_state_t state_d;
  logic        first_hold;
  logic        bubble_ins;

  // Hold state: remembers whether the previous edge was already frozen
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = ST_RUN;
    first_hold = 1'b0;
    if (hold_ex) begin
      state_d    = ST_FROZEN;
      first_hold = (state_q == ST_RUN);
    end
  end

  // Hold beats flush and stall; a held cycle never inserts a bubble
  assign bubble_ins = ~hold_ex & (flush_ex | stall_pipeline);

  // A flush redirects the front end, so a simultaneous stall must not freeze it
  assign front_hold = hold_ex | (stall_pipeline & ~flush_ex);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      fwd_a_q    <= FWD_NONE;
      fwd_b_q    <= FWD_NONE;
      fwd_st_q   <= FWD_NONE;
    end else if (hold_ex) begin
      // First frozen edge: capture the already-forwarded operands, since the
      // producing stages will move on while EX is busy.
      if (first_hold) begin
        if (!ctrl_q[CTRL_ALU_SRC]) begin
          rs1_data_q <= ex_op_a_res;
          rs2_data_q <= ex_op_b_res;
        end
        if (ctrl_q[CTRL_MEM_WRITE]) begin
          rs2_data_q <= ex_store_res;
        end
        fwd_a_q  <= FWD_NONE;
        fwd_b_q  <= FWD_NONE;
        fwd_st_q <= FWD_NONE;
      end
    end else if (flush_ex || stall_pipeline) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      fwd_a_q    <= FWD_NONE;
      fwd_b_q    <= FWD_NONE;
      fwd_st_q   <= FWD_NONE;
    end else begin
      valid_q    <= id_in.valid;
      pc_q       <= id_in.pc;
      rs1_data_q <= id_in.rs1_data;
      rs2_data_q <= id_in.rs2_data;
      imm_q      <= id_in.imm;
      rs1_q      <= id_in.rs1;
      rs2_q      <= id_in.rs2;
      rd_q       <= id_in.rd;
      ctrl_q     <= id_in.ctrl;
      fwd_a_q    <= id_in.fwd_a;
      fwd_b_q    <= id_in.fwd_b;
      fwd_st_q   <= id_in.fwd_st;
    end
  end

  // Bubble counter saturates instead of wrapping
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt_q <= '0;
    end else if (bubble_ins && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ex_out.valid    = valid_q;
  assign ex_out.pc       = pc_q;
  assign ex_out.rs1_data = rs1_data_q;
  assign ex_out.rs2_data = rs2_data_q;
  assign ex_out.imm      = imm_q;
  assign ex_out.rs1      = rs1_q;
  assign ex_out.rs2      = rs2_q;
  assign ex_out.rd       = rd_q;
  assign ex_out.ctrl     = ctrl_q;
  assign ex_out.fwd_a    = fwd_a_q;
  assign ex_out.fwd_b    = fwd_b_q;
  assign ex_out.fwd_st   = fwd_st_q;

  assign ex_reg_write = ctrl_q[CTRL_REG_WRITE] & valid_q;
  assign ex_is_load   = ctrl_q[CTRL_MEM_READ] & valid_q;
  assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// tb/tb_id_ex_stage_register.sv - scoreboard testbench for id_ex_stage_register
module tb_id_ex_stage_register;

  import core_pkg::*;

  logic        CLK;
  logic        RESETn;
  logic        stall_pipeline, flush_ex, hold_ex;
  logic [31:0] ex_op_a_res, ex_op_b_res, ex_store_res;
  logic        ex_reg_write, ex_is_load, front_hold;
  logic [15:0] bubble_cnt;
  logic        ex_reg_write2, ex_is_load2, front_hold2;
  logic [1:0]  bubble_cnt2;

  id_ex_stage_register_if id_if ();
  id_ex_stage_register_if ex_if ();
  id_ex_stage_register_if ex_if2 ();

  id_ex_stage_register dut (
    .CLK(CLK), .RESETn(RESETn), .id_in(id_if),
    .stall_pipeline(stall_pipeline), .flush_ex(flush_ex), .hold_ex(hold_ex),
    .ex_op_a_res(ex_op_a_res), .ex_op_b_res(ex_op_b_res), .ex_store_res(ex_store_res),
    .ex_out(ex_if), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .front_hold(front_hold), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage_register #(.CNT_W(2)) dut_sat (
    .CLK(CLK), .RESETn(RESETn), .id_in(id_if),
    .stall_pipeline(stall_pipeline), .flush_ex(flush_ex), .hold_ex(hold_ex),
    .ex_op_a_res(ex_op_a_res), .ex_op_b_res(ex_op_b_res), .ex_store_res(ex_store_res),
    .ex_out(ex_if2), .ex_reg_write(ex_reg_write2), .ex_is_load(ex_is_load2),
    .front_hold(front_hold2), .bubble_cnt(bubble_cnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rstn, valid, stall, flush, hold;
    logic [31:0] pc, rs1d, rs2d, imm, opa, opb, ops;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] ctrl;
    logic [1:0]  fa, fb, fs;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] ctrl;
    logic [1:0]  fa, fb, fs;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   fh_q[$];

  // Reference state: what EX should hold, whether the previous edge was held, bubbles since reset
  exp_t m;
  bit   m_frozen;
  int   m_bubbles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t empty_stage();
    exp_t e;
    e.valid = 0; e.pc = 0; e.rs1d = 0; e.rs2d = 0; e.imm = 0;
    e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.ctrl = 0; e.fa = 0; e.fb = 0; e.fs = 0;
    e.cnt = 0; e.cnt2 = 0;
    return e;
  endfunction

  function automatic void model_step(input stim_t s, input bit async_rst);
    if (!s.rstn || async_rst) begin
      m = empty_stage();
      m_frozen = 0;
      m_bubbles = 0;
    end else if (s.hold) begin
      if (!m_frozen) begin
        // instruction that just entered the multi-cycle op keeps its resolved operands
        if (!m.ctrl[CTRL_ALU_SRC]) begin
          m.rs1d = s.opa;
          m.rs2d = s.opb;
        end
        if (m.ctrl[CTRL_MEM_WRITE]) m.rs2d = s.ops;
        m.fa = FWD_NONE; m.fb = FWD_NONE; m.fs = FWD_NONE;
      end
      m_frozen = 1;
    end else begin
      m_frozen = 0;
      if (s.flush || s.stall) begin
        m = empty_stage();
        m_bubbles++;
      end else begin
        m.valid = s.valid; m.pc = s.pc; m.rs1d = s.rs1d; m.rs2d = s.rs2d; m.imm = s.imm;
        m.rs1 = s.rs1; m.rs2 = s.rs2; m.rd = s.rd; m.ctrl = s.ctrl;
        m.fa = s.fa; m.fb = s.fb; m.fs = s.fs;
      end
    end
    m.cnt  = (m_bubbles > 65535) ? 16'hFFFF : 16'(m_bubbles);
    m.cnt2 = (m_bubbles > 3) ? 2'd3 : 2'(m_bubbles);
  endfunction

  function automatic stim_t quiet_stim();
    stim_t s;
    s.rstn = 1; s.valid = 1; s.stall = 0; s.flush = 0; s.hold = 0;
    s.pc = $urandom; s.rs1d = $urandom; s.rs2d = $urandom; s.imm = $urandom;
    s.opa = $urandom; s.opb = $urandom; s.ops = $urandom;
    s.rs1 = 5'($urandom); s.rs2 = 5'($urandom); s.rd = 5'($urandom);
    s.ctrl = 12'($urandom);
    s.fa = 2'($urandom); s.fb = 2'($urandom); s.fs = 2'($urandom);
    return s;
  endfunction

  // Drive one cycle at the falling edge and record what the bench expects
  task automatic cycle(input stim_t s, input bit async_rst);
    @(negedge CLK);
    RESETn = s.rstn;
    id_if.valid = s.valid; id_if.pc = s.pc; id_if.rs1_data = s.rs1d; id_if.rs2_data = s.rs2d;
    id_if.imm = s.imm; id_if.rs1 = s.rs1; id_if.rs2 = s.rs2; id_if.rd = s.rd;
    id_if.ctrl = s.ctrl; id_if.fwd_a = s.fa; id_if.fwd_b = s.fb; id_if.fwd_st = s.fs;
    stall_pipeline = s.stall; flush_ex = s.flush; hold_ex = s.hold;
    ex_op_a_res = s.opa; ex_op_b_res = s.opb; ex_store_res = s.ops;
    fh_q.push_back(s.hold | (s.stall & ~s.flush));
    model_step(s, async_rst);
    exp_q.push_back(m);
    if (async_rst) begin
      #3 RESETn = 1'b0;
      #1;
      chk("async_rst_valid", ex_if.valid, 0);
      chk("async_rst_pc", ex_if.pc, 0);
      chk("async_rst_rs1_data", ex_if.rs1_data, 0);
      chk("async_rst_ctrl", ex_if.ctrl, 0);
      chk("async_rst_rd", ex_if.rd, 0);
      chk("async_rst_fwd_a", ex_if.fwd_a, 0);
      chk("async_rst_bubble_cnt", bubble_cnt, 0);
    end
  endtask

  // Monitor: registered outputs after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_valid", ex_if.valid, e.valid);
        chk("ex_pc", ex_if.pc, e.pc);
        chk("ex_rs1_data", ex_if.rs1_data, e.rs1d);
        chk("ex_rs2_data", ex_if.rs2_data, e.rs2d);
        chk("ex_imm", ex_if.imm, e.imm);
        chk("ex_rs1", ex_if.rs1, e.rs1);
        chk("ex_rs2", ex_if.rs2, e.rs2);
        chk("ex_rd", ex_if.rd, e.rd);
        chk("ex_ctrl", ex_if.ctrl, e.ctrl);
        chk("ex_fwd_a", ex_if.fwd_a, e.fa);
        chk("ex_fwd_b", ex_if.fwd_b, e.fb);
        chk("ex_fwd_st", ex_if.fwd_st, e.fs);
        chk("ex_reg_write", ex_reg_write, e.ctrl[CTRL_REG_WRITE] & e.valid);
        chk("ex_is_load", ex_is_load, e.ctrl[CTRL_MEM_READ] & e.valid);
        chk("bubble_cnt", bubble_cnt, e.cnt);
        chk("bubble_cnt_sat2", bubble_cnt2, e.cnt2);
      end
    end
  end

  // Monitor: combinational front_hold mid-cycle
  initial begin
    bit f;
    forever begin
      @(negedge CLK);
      #2;
      if (fh_q.size() > 0) begin
        f = fh_q.pop_front();
        chk("front_hold", front_hold, f);
      end
    end
  end

  initial begin
    stim_t s;
    int    hold_left;
    RESETn = 1'b0;
    id_if.valid = 0; id_if.pc = 0; id_if.rs1_data = 0; id_if.rs2_data = 0; id_if.imm = 0;
    id_if.rs1 = 0; id_if.rs2 = 0; id_if.rd = 0; id_if.ctrl = 0;
    id_if.fwd_a = 0; id_if.fwd_b = 0; id_if.fwd_st = 0;
    stall_pipeline = 0; flush_ex = 0; hold_ex = 0;
    ex_op_a_res = 0; ex_op_b_res = 0; ex_store_res = 0;
    m = empty_stage(); m_frozen = 0; m_bubbles = 0;

    // reset
    s = quiet_stim(); s.rstn = 0;
    cycle(s, 0);
    cycle(s, 0);

    // plain advance of a register-writing instruction
    s = quiet_stim(); s.pc = 32'h100; s.rd = 5; s.ctrl = 12'h0; s.ctrl[CTRL_REG_WRITE] = 1;
    s.fa = FWD_EX;
    cycle(s, 0);
    @(posedge CLK); #2;
    chk("t1_ex_pc", ex_if.pc, 32'h100);
    chk("t1_ex_rd", ex_if.rd, 5);
    chk("t1_ex_fwd_a", ex_if.fwd_a, FWD_EX);
    chk("t1_ex_reg_write", ex_reg_write, 1);

    // load-use: load into x7, then one stall cycle
    s = quiet_stim(); s.rd = 7; s.ctrl = 12'h0; s.ctrl[CTRL_MEM_READ] = 1;
    s.ctrl[CTRL_REG_WRITE] = 1; s.ctrl[CTRL_ALU_SRC] = 1;
    cycle(s, 0);
    @(posedge CLK); #2;
    chk("t2_ex_is_load", ex_is_load, 1);
    chk("t2_ex_rd", ex_if.rd, 7);
    s = quiet_stim(); s.stall = 1;
    cycle(s, 0);
    #1 chk("t2_front_hold", front_hold, 1);
    @(posedge CLK); #2;
    chk("t2_ex_valid", ex_if.valid, 0);
    chk("t2_ex_ctrl", ex_if.ctrl, 0);
    chk("t2_bubble_cnt", bubble_cnt, 1);

    // flush and stall together: one bubble, front end not held
    s = quiet_stim(); s.stall = 1; s.flush = 1;
    cycle(s, 0);
    #1 chk("t3_front_hold", front_hold, 0);
    @(posedge CLK); #2;
    chk("t3_ex_valid", ex_if.valid, 0);
    chk("t3_bubble_cnt", bubble_cnt, 2);

    // multi-cycle hold of a reg-reg op that was forwarding rs1 from MA
    s = quiet_stim(); s.ctrl = 12'h0; s.ctrl[CTRL_REG_WRITE] = 1; s.fa = FWD_MA;
    cycle(s, 0);
    for (int i = 0; i < 3; i++) begin
      s = quiet_stim(); s.hold = 1; s.stall = 1'($urandom); s.flush = 1'($urandom);
      if (i == 0) s.opa = 32'hDEAD_BEEF;
      cycle(s, 0);
      #1 chk("t4_front_hold", front_hold, 1);
      @(posedge CLK); #2;
      chk("t4_ex_rs1_data", ex_if.rs1_data, 32'hDEAD_BEEF);
      chk("t4_ex_fwd_a", ex_if.fwd_a, FWD_NONE);
    end

    // asynchronous reset in the middle of a hold, then resume
    s = quiet_stim(); s.ctrl[CTRL_ALU_SRC] = 0;
    cycle(s, 0);
    s = quiet_stim(); s.hold = 1;
    cycle(s, 0);
    s = quiet_stim(); s.hold = 1;
    cycle(s, 1);
    s = quiet_stim(); s.rstn = 0;
    cycle(s, 0);
    s = quiet_stim(); s.pc = 32'h0000_0400; s.valid = 1;
    cycle(s, 0);
    @(posedge CLK); #2;
    chk("t5_resume_pc", ex_if.pc, 32'h400);
    chk("t5_resume_valid", ex_if.valid, 1);

    // five stalls from a fresh reset: narrow counter stops at 3
    for (int i = 0; i < 5; i++) begin
      s = quiet_stim(); s.stall = 1;
      cycle(s, 0);
    end
    @(posedge CLK); #2;
    chk("t6_bubble_cnt_sat2", bubble_cnt2, 3);
    chk("t6_bubble_cnt", bubble_cnt, 5);

    // randomized traffic, including multi-cycle holds and occasional resets
    hold_left = 0;
    for (int n = 0; n < 600; n++) begin
      s = quiet_stim();
      s.valid = ($urandom_range(0, 4) != 0);
      s.stall = ($urandom_range(0, 5) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.rstn  = ($urandom_range(0, 149) != 0);
      if (hold_left > 0) begin
        s.hold = 1;
        hold_left--;
      end else if ($urandom_range(0, 7) == 0) begin
        s.hold = 1;
        hold_left = $urandom_range(0, 3);
      end
      cycle(s, ($urandom_range(0, 199) == 0));
      if (!RESETn && s.rstn) begin
        s = quiet_stim(); s.rstn = 0;
        cycle(s, 0);
      end
    end

    repeat (3) @(posedge CLK);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("front_hold_drained", fh_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
